// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 recoding; radix-2 is used when it is undefined.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } booth_state_e;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_ADD_M  = 3'd1,
      OP_SUB_M  = 3'd2,
      OP_ADD_2M = 3'd3,
      OP_SUB_2M = 3'd4
   } booth_op_e;

`ifdef BOOTH_RADIX4_EN
   localparam int BOOTH_SHIFT = 2;
`else
   localparam int BOOTH_SHIFT = 1;
`endif

   function automatic int booth_iter(input int width);
`ifdef BOOTH_RADIX4_EN
      return width / 2 + 1;
`else
      return width + 1;
`endif
   endfunction

   // Radix-4 table on {q1,q0,q-1}; radix-2 reuses it by feeding {q0,q0,q-1}.
   function automatic booth_op_e booth_recode(input logic [2:0] bits);
      booth_op_e op;
      case (bits)
         3'b000:  op = OP_NOP;
         3'b001:  op = OP_ADD_M;
         3'b010:  op = OP_ADD_M;
         3'b011:  op = OP_ADD_2M;
         3'b100:  op = OP_SUB_2M;
         3'b101:  op = OP_SUB_M;
         3'b110:  op = OP_SUB_M;
         3'b111:  op = OP_NOP;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Combinational Booth digit selection: recode bits and extended M in,
// positive-form addend (0, M or 2M) plus a subtract flag out.
module booth_digit_sel
   import booth_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic [2:0]    recode_i,
   input  logic [AW-1:0] m_ext_i,
   output logic [AW-1:0] addend_o,
   output logic          sub_o
);

   booth_op_e op_s;

   // Map the recoded digit onto an addend magnitude and a subtract request.
   always_comb begin
      op_s     = booth_recode(recode_i);
      addend_o = {AW{1'b0}};
      sub_o    = 1'b0;
      case (op_s)
         OP_NOP: begin
            addend_o = {AW{1'b0}};
            sub_o    = 1'b0;
         end
         OP_ADD_M: begin
            addend_o = m_ext_i;
            sub_o    = 1'b0;
         end
         OP_SUB_M: begin
            addend_o = m_ext_i;
            sub_o    = 1'b1;
         end
         OP_ADD_2M: begin
            addend_o = {m_ext_i[AW-2:0], 1'b0};
            sub_o    = 1'b0;
         end
         OP_SUB_2M: begin
            addend_o = {m_ext_i[AW-2:0], 1'b0};
            sub_o    = 1'b1;
         end
         default: begin
            addend_o = {AW{1'b0}};
            sub_o    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential Booth multiplier, one recoding step per clock, signed or unsigned.
// Radix-4 when BOOTH_RADIX4_EN is defined, radix-2 otherwise; results are identical.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int ITER = booth_iter(WIDTH);
   // Accumulator is WIDTH+3 so that +/-2M of a (WIDTH+2)-bit operand never overflows.
   localparam int AW   = WIDTH + 3;
   localparam int QW   = BOOTH_SHIFT * ITER;
   localparam int RW   = AW + QW + 1;
   localparam int CW   = $clog2(ITER + 1);

   booth_state_e       state_q;
   logic [AW-1:0]      m_q;
   logic [AW-1:0]      acc_q;
   logic [QW-1:0]      q_q;
   logic               qm1_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [2*WIDTH-1:0] product_q;

   logic [AW-1:0]      m_ext_s;
   logic [QW-1:0]      q_ext_s;
   logic [2:0]         recode_s;
   logic [AW-1:0]      addend_s;
   logic               sub_s;
   logic [AW-1:0]      sum_s;
   logic [RW-1:0]      shifted_s;
   logic [AW-1:0]      acc_d;
   logic [QW-1:0]      q_d;
   logic               qm1_d;
   logic [2*WIDTH-1:0] result_s;

   assign m_ext_s = {{(AW-WIDTH){signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
   assign q_ext_s = {{(QW-WIDTH){signed_mode & multiplier[WIDTH-1]}}, multiplier};

`ifdef BOOTH_RADIX4_EN
   assign recode_s = {q_q[1:0], qm1_q};
`else
   assign recode_s = {q_q[0], q_q[0], qm1_q};
`endif

   booth_digit_sel #(
      .AW (AW)
   ) u_digit_sel (
      .recode_i (recode_s),
      .m_ext_i  (m_q),
      .addend_o (addend_s),
      .sub_o    (sub_s)
   );

   // Two's-complement subtract folds the +1 into the carry-in position.
   assign sum_s     = acc_q + (addend_s ^ {AW{sub_s}}) + {{(AW-1){1'b0}}, sub_s};
   assign shifted_s = $signed({sum_s, q_q, qm1_q}) >>> BOOTH_SHIFT;
   assign acc_d     = shifted_s[RW-1 -: AW];
   assign q_d       = shifted_s[QW:1];
   assign qm1_d     = shifted_s[0];
   assign result_s  = shifted_s[2*WIDTH:1];

   // Control FSM with the Booth datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= {AW{1'b0}};
         acc_q     <= {AW{1'b0}};
         q_q       <= {QW{1'b0}};
         qm1_q     <= 1'b0;
         cnt_q     <= {CW{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= {(2*WIDTH){1'b0}};
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  m_q     <= m_ext_s;
                  acc_q   <= {AW{1'b0}};
                  q_q     <= q_ext_s;
                  qm1_q   <= 1'b0;
                  cnt_q   <= CW'(ITER);
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q   <= DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  product_q <= result_s;
               end else begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=8): directed spec cases plus
// random operands against an arithmetic reference model.
module tb_booth_seq_mult;

   localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
   localparam int ITER = W / 2 + 1;
`else
   localparam int ITER = W + 1;
`endif

   logic           clk;
   logic           rst_n;
   logic           start;
   logic           signed_mode;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int total = 0;
   int bad   = 0;

   booth_seq_mult #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .signed_mode  (signed_mode),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                                              input logic sm);
      longint a;
      longint b;
      longint p;
      if (sm) begin
         a = longint'($signed(m));
         b = longint'($signed(q));
      end else begin
         a = longint'(m);
         b = longint'(q);
      end
      p = a * b;
      return p[2*W-1:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at the sample point of the first cycle after the accepting edge.
   task automatic wait_done(input int glitch_at, output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         if (busy === 1'b1) busy_cnt++;
         if (c == glitch_at) begin
            start        = 1'b1;
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            signed_mode  = 1'($urandom);
         end else if (c == glitch_at + 1) begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic sm,
                         input int glitch_at, input string tag, output logic [2*W-1:0] obs);
      int lat;
      int bc;
      logic [2*W-1:0] exp;
      exp          = ref_mul(m, q, sm);
      multiplicand = m;
      multiplier   = q;
      signed_mode  = sm;
      start        = 1'b1;
      @(posedge clk); #1;
      start        = 1'b0;
      multiplicand = ~m;
      multiplier   = q ^ 8'h5A;
      signed_mode  = ~sm;
      wait_done(glitch_at, lat, bc);
      obs = product;
      chk({tag, " latency"}, 64'(lat), 64'(ITER + 1));
      chk({tag, " busy cycles"}, 64'(bc), 64'(ITER));
      chk({tag, " product"}, 64'(product), 64'(exp));
      @(posedge clk); #1;
      chk({tag, " done single pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [2*W-1:0] obs;
      logic [2*W-1:0] exp1;
      logic [2*W-1:0] exp2;
      logic [W-1:0]   rm;
      logic [W-1:0]   rq;
      logic           rs;
      int             lat;
      int             bc;

      rst_n        = 1'b0;
      start        = 1'b0;
      signed_mode  = 1'b0;
      multiplicand = 8'd0;
      multiplier   = 8'd0;
      #12;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset product", 64'(product), 64'd0);
      rst_n = 1'b1;

      run_op(8'h80, 8'h80, 1'b1, -5, "s -128x-128", obs);
      chk("s -128x-128 const", 64'(obs), 64'h4000);
      run_op(8'd7, 8'hFD, 1'b1, -5, "s 7x-3", obs);
      chk("s 7x-3 const", 64'(obs), 64'hFFEB);
      run_op(8'd255, 8'd255, 1'b0, -5, "u 255x255", obs);
      chk("u 255x255 const", 64'(obs), 64'hFE01);
      run_op(8'd0, 8'd200, 1'b0, -5, "u 0x200", obs);
      chk("u 0x200 const", 64'(obs), 64'h0000);
      run_op(8'h7F, 8'h80, 1'b1, -5, "s 127x-128", obs);
      run_op(8'h80, 8'd255, 1'b0, -5, "u 128x255", obs);

      run_op(8'd100, 8'd37, 1'b0, 2, "mid-run start ignored", obs);

      for (int i = 0; i < 16; i++) begin
         rm = W'($urandom);
         rq = W'($urandom);
         rs = 1'($urandom);
         run_op(rm, rq, rs, (i % 4 == 0) ? 3 : -5, "random", obs);
      end

      multiplicand = 8'd200;
      multiplier   = 8'd150;
      signed_mode  = 1'b0;
      exp1         = ref_mul(8'd200, 8'd150, 1'b0);
      exp2         = ref_mul(8'hF7, 8'd100, 1'b1);
      start        = 1'b1;
      @(posedge clk); #1;
      multiplicand = 8'hF7;
      multiplier   = 8'd100;
      signed_mode  = 1'b1;
      wait_done(-5, lat, bc);
      chk("b2b first latency", 64'(lat), 64'(ITER + 1));
      chk("b2b first product", 64'(product), 64'(exp1));
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b no idle bubble", 64'(busy), 64'd1);
      chk("b2b done dropped", 64'(done), 64'd0);
      wait_done(-5, lat, bc);
      chk("b2b second latency", 64'(lat), 64'(ITER + 1));
      chk("b2b second busy", 64'(bc), 64'(ITER));
      chk("b2b second product", 64'(product), 64'(exp2));
      @(posedge clk); #1;

      multiplicand = 8'd50;
      multiplier   = 8'd60;
      signed_mode  = 1'b0;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("abort busy before reset", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort product", 64'(product), 64'd0);
      #2;
      rst_n = 1'b1;
      run_op(8'd12, 8'd11, 1'b0, -5, "after abort 12x11", obs);
      chk("after abort 12x11 const", 64'(obs), 64'h0084);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
